// File: rtl/wrlvl_rank_sequencer_if.sv
// Bundles the training-controller, lane-response and DFI write-levelling signals
// of the rank sequencer.
interface wrlvl_rank_sequencer_if #(
  parameter int unsigned IOG_DQS_LANES = 9
) ();
  logic                     start;
  logic                     abort;
  logic [1:0]               rank_en;
  logic [IOG_DQS_LANES-1:0] wrlvl_resp;
  logic                     dfi_wrlvl_en;
  logic                     dfi_wrlvl_strobe;
  logic                     dfi_wrlvl_cs_0_n;
  logic                     dfi_wrlvl_cs_1_n;
  logic                     busy;
  logic                     done;
  logic [1:0]               rank_err;
  logic [15:0]              strobe_cnt;

  modport master (
    output start, abort, rank_en, wrlvl_resp,
    input  dfi_wrlvl_en, dfi_wrlvl_strobe, dfi_wrlvl_cs_0_n, dfi_wrlvl_cs_1_n,
           busy, done, rank_err, strobe_cnt
  );

  modport slave (
    input  start, abort, rank_en, wrlvl_resp,
    output dfi_wrlvl_en, dfi_wrlvl_strobe, dfi_wrlvl_cs_0_n, dfi_wrlvl_cs_1_n,
           busy, done, rank_err, strobe_cnt
  );
endinterface

// File: rtl/wrlvl_rank_sequencer.sv
// Sequences DDR write levelling over CS0 then CS1: periodic strobes until every
// DQS lane locks or the per-rank strobe budget runs out.
module wrlvl_rank_sequencer #(
  parameter int unsigned IOG_DQS_LANES = 9,
  parameter int unsigned EN_TO_STROBE  = 16,
  parameter int unsigned STROBE_GAP    = 32,
  parameter int unsigned MAX_STROBES   = 1024,
  parameter int unsigned RANK_GAP      = 16
) (
  input  logic                         SCLK,
  input  logic                         reset_n,
  wrlvl_rank_sequencer_if.slave        bus
);

  localparam int unsigned HOLD_A   = (EN_TO_STROBE > STROBE_GAP) ? EN_TO_STROBE : STROBE_GAP;
  localparam int unsigned HOLD_MAX = (HOLD_A > RANK_GAP) ? HOLD_A : RANK_GAP;
  localparam int unsigned CNT_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_STROBE   = 3'd2;
  localparam logic [2:0] S_GAP      = 3'd3;
  localparam logic [2:0] S_RANK_END = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(EN_TO_STROBE - 1);
  localparam logic [CNT_W-1:0] LOAD_GAP   = CNT_W'(STROBE_GAP - 2);
  localparam logic [CNT_W-1:0] LOAD_RANK  = CNT_W'(RANK_GAP - 1);

  logic [2:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             rank_q,       rank_d;
  logic             train_cs1_q,  train_cs1_d;
  logic             en_q,         en_d;
  logic             strobe_q,     strobe_d;
  logic             cs0_n_q,      cs0_n_d;
  logic             cs1_n_q,      cs1_n_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [1:0]       rank_err_q,   rank_err_d;
  logic [15:0]      strobe_cnt_q, strobe_cnt_d;

  logic [IOG_DQS_LANES-1:0] resp_c;
  logic                     all_locked_c;
  logic [15:0]              strobe_inc_c;
  logic                     budget_spent_c;

  assign resp_c         = bus.wrlvl_resp;
  assign all_locked_c   = &resp_c;
  assign strobe_inc_c   = (strobe_cnt_q == 16'hFFFF) ? strobe_cnt_q : strobe_cnt_q + 16'd1;
  assign budget_spent_c = strobe_cnt_q >= 16'(MAX_STROBES);

  // Next-state, counters and next registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rank_d       = rank_q;
    train_cs1_d  = train_cs1_q;
    rank_err_d   = rank_err_q;
    strobe_cnt_d = strobe_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    strobe_d     = 1'b0;
    en_d         = 1'b0;
    cs0_n_d      = 1'b1;
    cs1_n_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          train_cs1_d  = bus.rank_en[1];
          rank_err_d   = 2'b00;
          strobe_cnt_d = 16'd0;
          busy_d       = 1'b1;
          if (bus.rank_en == 2'b00) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = S_SETUP;
            rank_d  = ~bus.rank_en[0];
            cnt_d   = LOAD_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d      = S_STROBE;
          strobe_d     = 1'b1;
          strobe_cnt_d = strobe_inc_c;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STROBE: begin
        state_d = S_GAP;
        cnt_d   = LOAD_GAP;
      end
      S_GAP: begin
        // A lock seen in the final gap cycle still counts as a pass.
        if (all_locked_c) begin
          state_d = S_RANK_END;
          cnt_d   = LOAD_RANK;
        end else if (cnt_q == '0) begin
          if (budget_spent_c) begin
            state_d            = S_RANK_END;
            cnt_d              = LOAD_RANK;
            rank_err_d[rank_q] = 1'b1;
          end else begin
            state_d      = S_STROBE;
            strobe_d     = 1'b1;
            strobe_cnt_d = strobe_inc_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RANK_END: begin
        if (cnt_q == '0) begin
          if (!rank_q && train_cs1_q) begin
            state_d      = S_SETUP;
            rank_d       = 1'b1;
            strobe_cnt_d = 16'd0;
            cnt_d        = LOAD_SETUP;
          end else begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything but leaves the status registers untouched.
    if (state_q != S_IDLE && bus.abort) begin
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      strobe_d     = 1'b0;
      rank_err_d   = rank_err_q;
      strobe_cnt_d = strobe_cnt_q;
    end

    en_d    = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_GAP);
    cs0_n_d = ~(en_d && !rank_d);
    cs1_n_d = ~(en_d && rank_d);
  end

  // State and output registers.
  always_ff @(posedge SCLK) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rank_q       <= 1'b0;
      train_cs1_q  <= 1'b0;
      en_q         <= 1'b0;
      strobe_q     <= 1'b0;
      cs0_n_q      <= 1'b1;
      cs1_n_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rank_err_q   <= 2'b00;
      strobe_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rank_q       <= rank_d;
      train_cs1_q  <= train_cs1_d;
      en_q         <= en_d;
      strobe_q     <= strobe_d;
      cs0_n_q      <= cs0_n_d;
      cs1_n_q      <= cs1_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rank_err_q   <= rank_err_d;
      strobe_cnt_q <= strobe_cnt_d;
    end
  end

  assign bus.dfi_wrlvl_en     = en_q;
  assign bus.dfi_wrlvl_strobe = strobe_q;
  assign bus.dfi_wrlvl_cs_0_n = cs0_n_q;
  assign bus.dfi_wrlvl_cs_1_n = cs1_n_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.rank_err         = rank_err_q;
  assign bus.strobe_cnt       = strobe_cnt_q;

endmodule

// File: tb/tb_wrlvl_rank_sequencer.sv
// Scoreboard bench for wrlvl_rank_sequencer: expected strobe/done events are queued
// by the stimulus and matched by a negedge monitor.
module tb_wrlvl_rank_sequencer;

  localparam int unsigned LANES = 9;
  localparam int unsigned E     = 4;
  localparam int unsigned G     = 8;
  localparam int unsigned MAXS  = 4;
  localparam int unsigned R     = 3;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic        cs0_n;
    logic        cs1_n;
    logic [15:0] cnt;
    logic [1:0]  err;
  } ev_t;

  logic SCLK    = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   tests   = 0;
  int   failed  = 0;
  ev_t  exp_q[$];
  ev_t  mon_ev;
  int   k;

  wrlvl_rank_sequencer_if #(.IOG_DQS_LANES(LANES)) bus ();

  wrlvl_rank_sequencer #(
    .IOG_DQS_LANES(LANES),
    .EN_TO_STROBE (E),
    .STROBE_GAP   (G),
    .MAX_STROBES  (MAXS),
    .RANK_GAP     (R)
  ) dut (
    .SCLK   (SCLK),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 SCLK = ~SCLK;
  always @(posedge SCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns #1 after the posedge that brings cyc to n; inputs set then are sampled at edge n+1.
  task automatic after_edge(input int n);
    do begin
      @(posedge SCLK);
      #1;
    end while (cyc < n);
  endtask

  task automatic at_neg(input int n);
    do @(negedge SCLK); while (cyc < n);
  endtask

  task automatic issue_start(input logic [1:0] re, output int kk);
    @(posedge SCLK);
    #1;
    kk          = cyc + 1;
    bus.start   = 1'b1;
    bus.rank_en = re;
    after_edge(kk);
    bus.start   = 1'b0;
  endtask

  task automatic push_strobe(input int c, input logic c0, input logic c1, input int n);
    ev_t e;
    e.is_done = 1'b0; e.cyc = c; e.cs0_n = c0; e.cs1_n = c1; e.cnt = 16'(n); e.err = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c, input logic [1:0] err, input int n);
    ev_t e;
    e.is_done = 1'b1; e.cyc = c; e.cs0_n = 1'b1; e.cs1_n = 1'b1; e.cnt = 16'(n); e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe or done pulse must match the head of the expectation queue.
  always @(negedge SCLK) begin
    if (bus.dfi_wrlvl_strobe || bus.done) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_event: got strobe=%0b done=%0b at cycle %0d, expected none",
                 bus.dfi_wrlvl_strobe, bus.done, cyc);
      end else begin
        mon_ev = exp_q.pop_front();
        check("event_kind",  32'(bus.done), 32'(mon_ev.is_done));
        check("event_cycle", 32'(cyc),      32'(mon_ev.cyc));
        check("event_strobe_cnt", 32'(bus.strobe_cnt), 32'(mon_ev.cnt));
        if (bus.done) begin
          check("done_rank_err", 32'(bus.rank_err),     32'(mon_ev.err));
          check("done_en_low",   32'(bus.dfi_wrlvl_en), 32'(0));
        end else begin
          check("strobe_en",    32'(bus.dfi_wrlvl_en),     32'(1));
          check("strobe_cs0_n", 32'(bus.dfi_wrlvl_cs_0_n), 32'(mon_ev.cs0_n));
          check("strobe_cs1_n", 32'(bus.dfi_wrlvl_cs_1_n), 32'(mon_ev.cs1_n));
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag, input logic [1:0] err, input int cnt);
    check({tag, "_en"},       32'(bus.dfi_wrlvl_en),     32'(0));
    check({tag, "_strobe"},   32'(bus.dfi_wrlvl_strobe), 32'(0));
    check({tag, "_cs0_n"},    32'(bus.dfi_wrlvl_cs_0_n), 32'(1));
    check({tag, "_cs1_n"},    32'(bus.dfi_wrlvl_cs_1_n), 32'(1));
    check({tag, "_busy"},     32'(bus.busy),             32'(0));
    check({tag, "_done"},     32'(bus.done),             32'(0));
    check({tag, "_rank_err"}, 32'(bus.rank_err),         32'(err));
    check({tag, "_cnt"},      32'(bus.strobe_cnt),       32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.rank_en    = 2'b00;
    bus.wrlvl_resp = '0;

    at_neg(2);
    check_idle_outputs("reset", 2'b00, 0);
    after_edge(3);
    reset_n = 1'b1;

    // T1: CS0 only, lock 5 cycles after the third strobe.
    issue_start(2'b01, k);
    for (int i = 0; i < 3; i++) push_strobe(k + E + i * G, 1'b0, 1'b1, i + 1);
    push_done(k + E + 2 * G + 5 + R, 2'b00, 3);
    after_edge(k + E + 2 * G + 4);
    bus.wrlvl_resp = '1;
    after_edge(k + E + 2 * G + 5);
    bus.wrlvl_resp = '0;
    at_neg(k + E + 2 * G + 5 + R + 1);
    check_idle_outputs("t1_after", 2'b00, 3);

    // T2: both ranks, CS0 locks after 2 strobes, CS1 after 4; a start while busy is ignored.
    issue_start(2'b11, k);
    after_edge(k + 1);
    bus.start   = 1'b1;
    bus.rank_en = 2'b01;
    after_edge(k + 2);
    bus.start   = 1'b0;
    push_strobe(k + 4,  1'b0, 1'b1, 1);
    push_strobe(k + 12, 1'b0, 1'b1, 2);
    push_strobe(k + 22, 1'b1, 1'b0, 1);
    push_strobe(k + 30, 1'b1, 1'b0, 2);
    push_strobe(k + 38, 1'b1, 1'b0, 3);
    push_strobe(k + 46, 1'b1, 1'b0, 4);
    push_done(k + 52, 2'b00, 4);
    after_edge(k + 14);
    bus.wrlvl_resp = '1;
    after_edge(k + 15);
    bus.wrlvl_resp = '0;
    at_neg(k + 16);
    check("t2_gap_en",    32'(bus.dfi_wrlvl_en),     32'(0));
    check("t2_gap_cs0_n", 32'(bus.dfi_wrlvl_cs_0_n), 32'(1));
    check("t2_gap_cs1_n", 32'(bus.dfi_wrlvl_cs_1_n), 32'(1));
    check("t2_gap_busy",  32'(bus.busy),             32'(1));
    after_edge(k + 48);
    bus.wrlvl_resp = '1;
    after_edge(k + 49);
    bus.wrlvl_resp = '0;
    at_neg(k + 53);
    check_idle_outputs("t2_after", 2'b00, 4);

    // T3: CS1 only, lane 0 stuck low -> budget of 4 strobes exhausted.
    bus.wrlvl_resp = 9'h1FE;
    issue_start(2'b10, k);
    for (int i = 0; i < 4; i++) push_strobe(k + E + i * G, 1'b1, 1'b0, i + 1);
    push_done(k + 39, 2'b10, 4);
    at_neg(k + 41);
    check_idle_outputs("t3_after", 2'b10, 4);
    bus.wrlvl_resp = '0;

    // T4: no rank enabled -> immediate done, en never raised.
    issue_start(2'b00, k);
    push_done(k, 2'b00, 0);
    at_neg(k);
    check("t4_en_at_done", 32'(bus.dfi_wrlvl_en), 32'(0));
    check("t4_busy_at_done", 32'(bus.busy), 32'(1));
    at_neg(k + 1);
    check_idle_outputs("t4_after", 2'b00, 0);

    // T5: abort mid-gap on CS0, with an ignored start before it.
    issue_start(2'b11, k);
    after_edge(k + 1);
    bus.start   = 1'b1;
    bus.rank_en = 2'b00;
    after_edge(k + 2);
    bus.start   = 1'b0;
    push_strobe(k + 4, 1'b0, 1'b1, 1);
    after_edge(k + 7);
    bus.abort = 1'b1;
    after_edge(k + 8);
    bus.abort = 1'b0;
    at_neg(k + 8);
    check_idle_outputs("t5_abort", 2'b00, 1);
    at_neg(k + 40);
    check_idle_outputs("t5_later", 2'b00, 1);

    // T6: reset pulse during STROBE, then a fresh single-strobe run.
    issue_start(2'b01, k);
    push_strobe(k + 4, 1'b0, 1'b1, 1);
    after_edge(k + 4);
    reset_n = 1'b0;
    after_edge(k + 5);
    reset_n = 1'b1;
    at_neg(k + 5);
    check_idle_outputs("t6_reset", 2'b00, 0);
    issue_start(2'b01, k);
    push_strobe(k + 4, 1'b0, 1'b1, 1);
    push_done(k + 9, 2'b00, 1);
    after_edge(k + 5);
    bus.wrlvl_resp = '1;
    after_edge(k + 6);
    bus.wrlvl_resp = '0;
    at_neg(k + 12);
    check_idle_outputs("t6_after", 2'b00, 1);

    at_neg(cyc + 10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
